regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-port integer register file with a built-in per-register scoreboard, serving the decode and writeback stages of the pipelined core.
- NRD combinational read ports and NWR synchronous write ports.
- Write-to-read bypass within the same cycle.
- Register 0 is hard-wired to zero.
- Per-register pending bits are set when an instruction issues with that destination and cleared when it writes back, so decode can detect RAW hazards.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >= 2)
NRD, 2, number of read ports
NWR, 2, number of write ports; a higher index means a younger producer
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
we  in  NWR  per-port write enable
waddr  in  NWR*AW  packed write addresses, port i at [i*AW +: AW]
wdata  in  NWR*XLEN  packed write data, port i at [i*XLEN +: XLEN]
re  in  NRD  per-port read enable
raddr  in  NRD*AW  packed read addresses
rdata  out  NRD*XLEN  packed read data
rbusy  out  NRD  read source still pending after this cycle's writebacks
set_en  in  1  mark set_addr pending (issue of a destination)
set_addr  in  AW  destination register being issued
flush  in  1  clear all pending bits (pipeline flush)
busy_vec  out  NREG  current pending bits, bit 0 always 0
pend_cnt  out  AW+1  number of set bits in busy_vec (registered)

Behaviour:
- Reset (rst=1 at a clock edge):
  - all registers become 0; busy_vec and pend_cnt become 0.
  - Writes, set_en and flush are ignored in that cycle.
  - While rst is high, rdata=0 and rbusy=0 on every port.
- Write:
  - At a clock edge, for each port i with we[i]=1 and waddr[i]!=0, the register takes wdata[i].
  - If two ports target the same address, the highest-indexed port wins.
  - Writes to address 0 are discarded.
- Read (combinational, zero latency):
  - rdata[j]=0 if rst, !re[j], or raddr[j]==0.
  - Otherwise, if any port has we[i] and waddr[i]==raddr[j], rdata[j] is wdata of the highest such i (bypass).
  - Otherwise rdata[j] is the stored register.
- rbusy[j]:
  - Equals re[j] && raddr[j]!=0 && busy_vec[raddr[j]] && no write port writing raddr[j] this cycle.
  - A same-cycle writeback therefore resolves the hazard.
- Scoreboard update at the clock edge, in priority order:
  1. rst: all pending bits clear.
  2. flush: all pending bits clear; set_en in the same cycle is ignored.
  3. Writeback: any write to address a (a!=0) clears bit a.
  4. Issue: set_en with set_addr!=0 sets bit set_addr. If the same address is also written back in that cycle, set wins (newer producer outstanding).
- set_en to address 0 has no effect; bit 0 is constant 0.
- pend_cnt: registered population count of next-state busy_vec, so it always equals popcount(busy_vec). It never exceeds NREG-1.
- Re-setting an already-pending register leaves the bit at 1; there is no counting of multiple producers.

Decomposition:
- Shared package: XLEN, NREG and the derived AW constants, plus a reg_addr_t typedef, so decode and writeback stages share them.
- One natural sub-module, regfile_sb_popcnt: NREG-bit population counter feeding pend_cnt.
- Bypass and priority muxing stay inline.

Test Plan:
1. Reset then read: rst for 2 cycles, release, read x1..x31 on both ports -> all rdata=0, busy_vec=0, pend_cnt=0.
2. Write/read and x0:
   - we[0]=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr[0]=5 -> 0xDEADBEEF.
   - Write x0=0x1234 -> reading x0 returns 0.
3. Dual-write conflict and bypass: same cycle we=2'b11, both waddr=7, wdata0=0x11, wdata1=0x22, raddr[1]=7 -> rdata[1]=0x22 that cycle; x7=0x22 afterwards.
4. Scoreboard hazard:
   - set_en, set_addr=9 -> busy_vec[9]=1, pend_cnt=1; raddr[0]=9 -> rbusy[0]=1.
   - Next cycle write x9=0x55 -> rbusy[0]=0 and rdata[0]=0x55 in that cycle; busy_vec[9]=0 after the edge.
5. Set/clear collision and flush:
   - Pending x3, then set_en=3 with writeback to 3 in the same cycle -> busy_vec[3] remains 1.
   - Set x4 and x6, then flush with set_en=8 -> busy_vec=0, pend_cnt=0.
6. Reset mid-operation: busy bits set and registers written, then assert rst together with we and set_en -> all state 0, the write is not committed.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
// Decode and writeback stages import this so that they agree on widths.
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;
    localparam int DEF_NWR  = 2;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_popcnt.sv
// Population counter over a pending-bit vector.
module regfile_sb_popcnt #(
    parameter int N = 32,
    parameter int W = 6
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] cnt
);

    // Sum of all set bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(vec[i]);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and a
// per-register pending scoreboard for RAW hazard detection at decode.
// Register 0 reads as zero and can never be marked pending.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD,
    parameter int NWR  = DEF_NWR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NWR-1:0]             we,
    input  logic [NWR*$clog2(NREG)-1:0] waddr,
    input  logic [NWR*XLEN-1:0]        wdata,
    input  logic [NRD-1:0]             re,
    input  logic [NRD*$clog2(NREG)-1:0] raddr,
    output logic [NRD*XLEN-1:0]        rdata,
    output logic [NRD-1:0]             rbusy,
    input  logic                       set_en,
    input  logic [$clog2(NREG)-1:0]    set_addr,
    input  logic                       flush,
    output logic [NREG-1:0]            busy_vec,
    output logic [$clog2(NREG):0]      pend_cnt
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;

    // Register writes; ascending port order lets the youngest producer win.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && (waddr[i*AW +: AW] != '0)) begin
                regs_d[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: flush beats everything, issue beats writeback.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i]) begin
                    busy_d[waddr[i*AW +: AW]] = 1'b0;
                end
            end
            if (set_en) begin
                busy_d[set_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Count is taken on the next-state vector so the registered value tracks busy_q.
    regfile_sb_popcnt #(
        .N (NREG),
        .W (AW + 1)
    ) u_popcnt (
        .vec (busy_d),
        .cnt (pend_cnt_d)
    );

    // State registers; reset discards any write, issue or flush in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Combinational read ports with write bypass; a bypass hit also clears the hazard.
    always_comb begin
        logic            hit;
        logic [XLEN-1:0] val;
        logic [AW-1:0]   ra;
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            ra  = raddr[j*AW +: AW];
            hit = 1'b0;
            val = regs_q[ra];
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    val = wdata[i*XLEN +: XLEN];
                end
            end
            if (!rst && re[j] && (ra != '0)) begin
                rdata[j*XLEN +: XLEN] = val;
                rbusy[j]              = busy_q[ra] && !hit;
            end
        end
    end

    assign busy_vec = busy_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs computed by
// a behavioural model; an independent monitor pops and compares on negedge.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = $clog2(NREG);

    logic                 clk;
    logic                 rst;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 set_en;
    logic [AW-1:0]        set_addr;
    logic                 flush;
    logic [NREG-1:0]      busy_vec;
    logic [AW:0]          pend_cnt;

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .set_en   (set_en),
        .set_addr (set_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .pend_cnt (pend_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NRD*XLEN-1:0] rdata;
        logic [NRD-1:0]      rbusy;
        logic [NREG-1:0]     busy;
        logic [AW:0]         pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Architectural model: register contents and set of outstanding destinations.
    int unsigned m_mem  [NREG];
    bit          m_busy [NREG];

    function automatic int unsigned wa(int i);
        logic [NWR*AW-1:0] v;
        v = waddr;
        return int'(v[i*AW +: AW]);
    endfunction

    function automatic int unsigned wd(int i);
        logic [NWR*XLEN-1:0] v;
        v = wdata;
        return int'(v[i*XLEN +: XLEN]);
    endfunction

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        set_en = 1'b0; set_addr = '0; flush = 1'b0;
    endtask

    task automatic wr(int port, int unsigned a, int unsigned d);
        we[port] = 1'b1;
        waddr[port*AW +: AW] = AW'(a);
        wdata[port*XLEN +: XLEN] = XLEN'(d);
    endtask

    task automatic rd(int port, int unsigned a);
        re[port] = 1'b1;
        raddr[port*AW +: AW] = AW'(a);
    endtask

    // Predict this cycle's outputs, then advance the model across the clock edge.
    task automatic step();
        exp_t        e;
        int unsigned a;
        int unsigned cnt;
        int          src;
        e.rdata = '0;
        e.rbusy = '0;
        e.busy  = '0;
        for (int j = 0; j < NRD; j++) begin
            a = int'(raddr[j*AW +: AW]);
            if (!rst && re[j] && a != 0) begin
                src = -1;
                for (int i = NWR - 1; i >= 0; i--) begin
                    if (src < 0 && we[i] && wa(i) == a) src = i;
                end
                e.rdata[j*XLEN +: XLEN] = (src >= 0) ? XLEN'(wd(src)) : XLEN'(m_mem[a]);
                e.rbusy[j] = m_busy[a] && (src < 0);
            end
        end
        cnt = 0;
        for (int r = 0; r < NREG; r++) begin
            e.busy[r] = m_busy[r];
            if (m_busy[r]) cnt++;
        end
        e.pend = (AW+1)'(cnt);
        exp_q.push_back(e);

        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r]  = 0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                src = -1;
                for (int i = NWR - 1; i >= 0; i--) begin
                    if (src < 0 && we[i] && wa(i) == r) src = i;
                end
                if (src >= 0) m_mem[r] = wd(src);
            end
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    if (we[i]) m_busy[wa(i)] = 1'b0;
                end
                if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
            end
        end
        #1;
    endtask

    // Monitor: compares DUT outputs against queued expectations away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata t=%0t: got %h expected %h", $time, rdata, e.rdata);
                end
                checks++;
                if (rbusy !== e.rbusy) begin
                    errors++;
                    $display("FAIL rbusy t=%0t: got %b expected %b", $time, rbusy, e.rbusy);
                end
                checks++;
                if (busy_vec !== e.busy) begin
                    errors++;
                    $display("FAIL busy_vec t=%0t: got %h expected %h", $time, busy_vec, e.busy);
                end
                checks++;
                if (pend_cnt !== e.pend) begin
                    errors++;
                    $display("FAIL pend_cnt t=%0t: got %0d expected %0d", $time, pend_cnt, e.pend);
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = 0;
            m_busy[r] = 1'b0;
        end
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // reset state readback
        for (int a = 1; a < NREG; a++) begin
            idle(); rd(0, a); rd(1, a); step();
        end

        // write/read and x0
        idle(); wr(0, 5, 32'hDEADBEEF); step();
        idle(); rd(0, 5); step();
        idle(); wr(0, 0, 32'h1234); rd(1, 0); step();
        idle(); rd(0, 0); rd(1, 5); step();

        // dual-write conflict with bypass
        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(1, 7); rd(0, 7); step();
        idle(); rd(0, 7); step();

        // scoreboard hazard resolved by writeback
        idle(); set_en = 1'b1; set_addr = 9; rd(0, 9); step();
        idle(); rd(0, 9); step();
        idle(); rd(0, 9); wr(1, 9, 32'h55); step();
        idle(); rd(0, 9); step();

        // set/clear collision and flush
        idle(); set_en = 1'b1; set_addr = 3; step();
        idle(); set_en = 1'b1; set_addr = 3; wr(0, 3, 32'h33); rd(0, 3); step();
        idle(); rd(0, 3); step();
        idle(); set_en = 1'b1; set_addr = 4; step();
        idle(); set_en = 1'b1; set_addr = 6; step();
        idle(); flush = 1'b1; set_en = 1'b1; set_addr = 8; step();
        idle(); rd(0, 8); step();
        idle(); set_en = 1'b1; set_addr = 0; step();
        idle(); step();

        // reset mid-operation with a write and an issue in the same cycle
        idle(); set_en = 1'b1; set_addr = 10; wr(0, 11, 32'hABCD); step();
        idle(); rd(0, 11); rd(1, 10); step();
        idle(); rst = 1'b1; wr(1, 12, 32'h77); set_en = 1'b1; set_addr = 13; rd(0, 11); step();
        rst = 1'b0;
        idle(); rd(0, 11); rd(1, 12); step();
        idle(); rd(0, 13); step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NWR; i++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1), $urandom());
            end
            for (int j = 0; j < NRD; j++) begin
                if ($urandom_range(0, 3) != 0)
                    rd(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
                else
                    raddr[j*AW +: AW] = AW'($urandom_range(0, NREG - 1));
            end
            set_en   = ($urandom_range(0, 9) < 4);
            set_addr = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0;
        idle();

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
